// File: rtl/alu_ctrl_stage_pkg.sv
// Shared encodings for the execute-stage ALU control path: opcodes, ALU Oper codes,
// result kinds and the decoded control bundle carried by stage E.
package alu_ctrl_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int OPER_W  = 4;

  // Opcodes (instr[15:11]) that need individual treatment
  localparam logic [4:0] OPC_ALU  = 5'b11011;
  localparam logic [4:0] OPC_SHFT = 5'b11010;
  localparam logic [4:0] OPC_SEQ  = 5'b11100;
  localparam logic [4:0] OPC_SLT  = 5'b11101;
  localparam logic [4:0] OPC_SLE  = 5'b11110;
  localparam logic [4:0] OPC_SCO  = 5'b11111;
  localparam logic [4:0] OPC_BTR  = 5'b11001;
  localparam logic [4:0] OPC_LBI  = 5'b11000;

  // ALU Oper codes: 00xx shifts/rotates, 01xx add/sub/xor/andn, 1xxx special
  localparam logic [3:0] OPER_ADD    = 4'b0100;
  localparam logic [3:0] OPER_SUB    = 4'b0101;
  localparam logic [3:0] OPER_OP     = 4'b1000;
  localparam logic [3:0] OPER_OPSHFT = 4'b1001;
  localparam logic [3:0] OPER_PASSA  = 4'b1010;
  localparam logic [3:0] OPER_PASSB  = 4'b1011;
  localparam logic [3:0] OPER_BTR    = 4'b1100;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_SET  = 2'b01,
    KIND_BR   = 2'b10
  } kind_e;

  typedef struct packed {
    logic [3:0] oper;
    logic [1:0] instruct;
    logic       sign;
    kind_e      kind;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_stage_cond_resolve.sv
// Resolves a set/branch condition from the opcode held in stage R and the ALU flags
// captured with it. SUB computes Rt-Rs, so "less than" reads as a non-negative result.
module alu_ctrl_stage_cond_resolve
  import alu_ctrl_stage_pkg::*;
(
  input  logic [4:0] op,
  input  kind_e      kind,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic       cf,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (kind)
      KIND_SET: begin
        case (op)
          OPC_SEQ: cond = zf;
          OPC_SLT: cond = !zf && (sf == of);
          OPC_SLE: cond = (sf == of);
          OPC_SCO: cond = cf;
          default: cond = 1'b0;
        endcase
      end
      KIND_BR: begin
        case (op[1:0])
          2'b00:   cond = zf;
          2'b01:   cond = !zf;
          2'b10:   cond = sf;
          default: cond = !sf;
        endcase
      end
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Execute-stage ALU control: decodes an instruction into stage E (drives the ALU), then
// captures the ALU flags into stage R where the set/branch condition is resolved.
module alu_ctrl_stage
  import alu_ctrl_stage_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_W,
  parameter int OPER_WIDTH  = OPER_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   alu_valid,
  output logic [OPER_WIDTH-1:0]  alu_oper,
  output logic [1:0]             alu_instruct,
  output logic                   alu_invA,
  output logic                   alu_invB,
  output logic                   alu_cin,
  output logic                   alu_sign,
  input  logic                   alu_zf,
  input  logic                   alu_sf,
  input  logic                   alu_of,
  input  logic                   alu_cf,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [1:0]             res_kind,
  output logic                   res_cond
);

  function automatic ctrl_t decode_instr(input logic [4:0] op, input logic [1:0] funct);
    ctrl_t c;
    c.oper     = OPER_ADD;
    c.instruct = 2'b00;
    c.sign     = 1'b0;
    c.kind     = KIND_NONE;
    casez (op)
      OPC_ALU:  begin c.oper = OPER_OP;     c.instruct = funct; c.sign = 1'b1; end
      OPC_SHFT: begin c.oper = OPER_OPSHFT; c.instruct = funct; end
      5'b010??: begin c.oper = {2'b01, op[1:0]}; c.sign = 1'b1; end
      5'b101??: c.oper = {2'b00, op[1:0]};
      OPC_SEQ, OPC_SLT, OPC_SLE: begin
        c.oper = OPER_SUB; c.sign = 1'b1; c.kind = KIND_SET;
      end
      OPC_SCO:  c.kind = KIND_SET;
      5'b011??: begin c.oper = OPER_PASSA; c.kind = KIND_BR; end
      OPC_BTR:  c.oper = OPER_BTR;
      OPC_LBI:  c.oper = OPER_PASSB;
      default:  ;
    endcase
    return c;
  endfunction

  logic [4:0] in_op;
  logic       unused_instr_bits;
  ctrl_t      dec;
  logic       r_adv, e_adv, accept;

  logic [4:0] e_op;
  kind_e      e_kind;
  logic [4:0] r_op;
  kind_e      r_kind;
  logic       r_zf, r_sf, r_of, r_cf;

  assign in_op             = in_instr[15:11];
  assign unused_instr_bits = ^in_instr[10:2];
  assign dec               = decode_instr(in_op, in_instr[1:0]);

  // Valid/ready: a stage transfers when its valid and the downstream ready are both high.
  // R frees when empty or drained; E moves into R when R frees; E accepts when empty or
  // moving. flush blocks acceptance in the same cycle and empties both stages next edge.
  assign r_adv    = !res_valid || res_ready;
  assign e_adv    = alu_valid && r_adv;
  assign in_ready = (!alu_valid || r_adv) && !flush;
  assign accept   = in_valid && in_ready;

  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_cin  = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_valid    <= 1'b0;
      alu_oper     <= '0;
      alu_instruct <= 2'b00;
      alu_sign     <= 1'b0;
      e_op         <= 5'd0;
      e_kind       <= KIND_NONE;
    end else if (flush) begin
      alu_valid <= 1'b0;
    end else if (accept) begin
      alu_valid    <= 1'b1;
      alu_oper     <= dec.oper;
      alu_instruct <= dec.instruct;
      alu_sign     <= dec.sign;
      e_op         <= in_op;
      e_kind       <= dec.kind;
    end else if (e_adv) begin
      alu_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      r_op      <= 5'd0;
      r_kind    <= KIND_NONE;
      r_zf      <= 1'b0;
      r_sf      <= 1'b0;
      r_of      <= 1'b0;
      r_cf      <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (e_adv) begin
      res_valid <= 1'b1;
      r_op      <= e_op;
      r_kind    <= e_kind;
      r_zf      <= alu_zf;
      r_sf      <= alu_sf;
      r_of      <= alu_of;
      r_cf      <= alu_cf;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_kind = r_kind;

  alu_ctrl_stage_cond_resolve u_cond_resolve (
    .op   (r_op),
    .kind (r_kind),
    .zf   (r_zf),
    .sf   (r_sf),
    .of   (r_of),
    .cf   (r_cf),
    .cond (res_cond)
  );

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: directed decode/condition vectors, back-pressure, flush and
// reset sequences, then a random stream checked against a pipeline-occupancy model.
module tb_alu_ctrl_stage;
  import alu_ctrl_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [15:0] in_instr;
  logic        alu_valid, alu_invA, alu_invB, alu_cin, alu_sign;
  logic [3:0]  alu_oper;
  logic [1:0]  alu_instruct;
  logic        alu_zf, alu_sf, alu_of, alu_cf;
  logic        res_valid, res_ready, res_cond;
  logic [1:0]  res_kind;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_valid(alu_valid), .alu_oper(alu_oper), .alu_instruct(alu_instruct),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_cin(alu_cin), .alu_sign(alu_sign),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .alu_cf(alu_cf),
    .res_valid(res_valid), .res_ready(res_ready), .res_kind(res_kind), .res_cond(res_cond)
  );

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  flags;   // {zf, sf, of, cf}
    logic [3:0]  oper;
    logic [1:0]  instruct;
    logic        sign;
    logic [1:0]  kind;
    logic        cond;
  } vec_t;

  vec_t vecs[18];

  // Pipeline model state for the random stream
  logic        m_e_full = 1'b0;
  logic        m_r_full = 1'b0;
  logic [15:0] inst_q[$];
  logic [2:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_ctrl(input logic [15:0] ins);
    int op;
    logic [3:0] oper;
    logic [1:0] f;
    logic s;
    op = int'(ins[15:11]);
    oper = OPER_ADD;
    f = 2'b00;
    s = 1'b0;
    if (op == 27) begin oper = OPER_OP; f = ins[1:0]; s = 1'b1; end
    else if (op == 26) begin oper = OPER_OPSHFT; f = ins[1:0]; end
    else if (op / 4 == 2) begin oper = 4'(4 + op % 4); s = 1'b1; end
    else if (op / 4 == 5) oper = 4'(op % 4);
    else if (op >= 28 && op <= 30) begin oper = OPER_SUB; s = 1'b1; end
    else if (op / 4 == 3) oper = OPER_PASSA;
    else if (op == 25) oper = OPER_BTR;
    else if (op == 24) oper = OPER_PASSB;
    return {oper, f, s};
  endfunction

  function automatic logic [2:0] model_res(input logic [15:0] ins, input logic [3:0] flg);
    int op;
    logic zf, sf, of, cf;
    op = int'(ins[15:11]);
    {zf, sf, of, cf} = flg;
    case (op)
      28: return {2'b01, zf};
      29: return {2'b01, !zf && (sf == of)};
      30: return {2'b01, sf == of};
      31: return {2'b01, cf};
      12: return {2'b10, zf};
      13: return {2'b10, !zf};
      14: return {2'b10, sf};
      15: return {2'b10, !sf};
      default: return 3'b000;
    endcase
  endfunction

  task automatic step(input logic iv, input logic [15:0] ins, input logic rr,
                      input logic fl, input logic [3:0] flg);
    logic r_free, e_move, acc;
    @(negedge clk);
    in_valid = iv; in_instr = ins; res_ready = rr; flush = fl;
    {alu_zf, alu_sf, alu_of, alu_cf} = flg;
    #1;
    r_free = !m_r_full || rr;
    chk("rnd_in_ready", 32'(in_ready), 32'((!m_e_full || r_free) && !fl));
    chk("rnd_alu_valid", 32'(alu_valid), 32'(m_e_full));
    chk("rnd_res_valid", 32'(res_valid), 32'(m_r_full));
    if (m_e_full && inst_q.size() > 0)
      chk("rnd_alu_ctrl", 32'({alu_oper, alu_instruct, alu_sign}), 32'(model_ctrl(inst_q[0])));
    if (m_r_full && rr && exp_q.size() > 0)
      chk("rnd_res", 32'({res_kind, res_cond}), 32'(exp_q[0]));
    if (fl) begin
      m_e_full = 1'b0; m_r_full = 1'b0;
      inst_q.delete(); exp_q.delete();
    end else begin
      e_move = m_e_full && r_free;
      acc    = iv && (!m_e_full || r_free);
      if (m_r_full && rr && exp_q.size() > 0) void'(exp_q.pop_front());
      if (e_move) begin
        exp_q.push_back(model_res(inst_q.pop_front(), flg));
        m_r_full = 1'b1;
      end else if (rr) m_r_full = 1'b0;
      if (acc) begin
        inst_q.push_back(ins);
        m_e_full = 1'b1;
      end else if (e_move) m_e_full = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    in_valid = 1'b1; in_instr = v.instr; res_ready = 1'b1; flush = 1'b0;
    {alu_zf, alu_sf, alu_of, alu_cf} = v.flags;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk($sformatf("vec%0d_alu_valid", idx), 32'(alu_valid), 32'd1);
    chk($sformatf("vec%0d_alu_ctrl", idx), 32'({alu_oper, alu_instruct, alu_sign}),
        32'({v.oper, v.instruct, v.sign}));
    @(negedge clk);
    #1;
    chk($sformatf("vec%0d_res_valid", idx), 32'(res_valid), 32'd1);
    chk($sformatf("vec%0d_res", idx), 32'({res_kind, res_cond}), 32'({v.kind, v.cond}));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alu_valid"}, 32'(alu_valid), 32'd0);
    chk({tag, "_alu_ctrl"}, 32'({alu_oper, alu_instruct, alu_sign}), 32'd0);
    chk({tag, "_const"}, 32'({alu_invA, alu_invB, alu_cin}), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res"}, 32'({res_kind, res_cond}), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{16'hD94C, 4'b0000, OPER_ADD == 4'b0100 ? 4'b1000 : 4'b1000, 2'b00, 1'b1, 2'b00, 1'b0};
    vecs[1]  = '{16'hE800, 4'b0000, 4'b0101, 2'b00, 1'b1, 2'b01, 1'b1};
    vecs[2]  = '{16'hE800, 4'b0100, 4'b0101, 2'b00, 1'b1, 2'b01, 1'b0};
    vecs[3]  = '{16'hE800, 4'b1000, 4'b0101, 2'b00, 1'b1, 2'b01, 1'b0};
    vecs[4]  = '{16'h7800, 4'b0100, 4'b1010, 2'b00, 1'b0, 2'b10, 1'b0};
    vecs[5]  = '{16'h6000, 4'b1000, 4'b1010, 2'b00, 1'b0, 2'b10, 1'b1};
    vecs[6]  = '{16'hE000, 4'b1000, 4'b0101, 2'b00, 1'b1, 2'b01, 1'b1};
    vecs[7]  = '{16'hF000, 4'b1000, 4'b0101, 2'b00, 1'b1, 2'b01, 1'b1};
    vecs[8]  = '{16'hF800, 4'b0001, 4'b0100, 2'b00, 1'b0, 2'b01, 1'b1};
    vecs[9]  = '{16'h4800, 4'b0000, 4'b0101, 2'b00, 1'b1, 2'b00, 1'b0};
    vecs[10] = '{16'hB800, 4'b0000, 4'b0011, 2'b00, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{16'hD003, 4'b0000, 4'b1001, 2'b11, 1'b0, 2'b00, 1'b0};
    vecs[12] = '{16'hC800, 4'b1111, 4'b1100, 2'b00, 1'b0, 2'b00, 1'b0};
    vecs[13] = '{16'hC000, 4'b0000, 4'b1011, 2'b00, 1'b0, 2'b00, 1'b0};
    vecs[14] = '{16'h8800, 4'b1111, 4'b0100, 2'b00, 1'b0, 2'b00, 1'b0};
    vecs[15] = '{16'h6800, 4'b0000, 4'b1010, 2'b00, 1'b0, 2'b10, 1'b1};
    vecs[16] = '{16'h7000, 4'b0100, 4'b1010, 2'b00, 1'b0, 2'b10, 1'b1};
    vecs[17] = '{16'hD94E, 4'b0000, 4'b1000, 2'b10, 1'b1, 2'b00, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; res_ready = 1'b1;
    {alu_zf, alu_sf, alu_of, alu_cf} = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Back-pressure: SCO then LBI get in, BEQZ is held off while R is stalled
    @(negedge clk);
    in_valid = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    res_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hF800;
    {alu_zf, alu_sf, alu_of, alu_cf} = 4'b0001;
    #1 chk("bp_ready0", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_instr = 16'hC000;
    #1 chk("bp_ready1", 32'(in_ready), 32'd1);
    chk("bp_e_sco", 32'(alu_oper), 32'(OPER_ADD));
    @(negedge clk);
    in_instr = 16'h6000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready_stall", 32'(in_ready), 32'd0);
      chk("bp_hold_e", 32'({alu_valid, alu_oper}), 32'({1'b1, OPER_PASSB}));
      chk("bp_hold_r", 32'({res_valid, res_kind, res_cond}), 32'({1'b1, 2'b01, 1'b1}));
      @(negedge clk);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    #1 chk("bp_drain_a", 32'({res_valid, res_kind, res_cond}), 32'({1'b1, 2'b01, 1'b1}));
    @(negedge clk);
    #1 chk("bp_drain_b", 32'({res_valid, res_kind, alu_valid}), 32'({1'b1, 2'b00, 1'b0}));
    @(negedge clk);
    #1 chk("bp_empty", 32'({res_valid, alu_valid}), 32'd0);

    // Flush with both stages full and a new instruction offered
    @(negedge clk);
    res_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hD94C;
    @(negedge clk);
    in_instr = 16'hE800;
    @(negedge clk);
    #1 chk("fl_full", 32'({alu_valid, res_valid}), 32'b11);
    in_instr = 16'hF800; flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("fl_valids", 32'({alu_valid, res_valid}), 32'd0);
    @(negedge clk);
    #1 chk("fl_nothing_taken", 32'({alu_valid, res_valid}), 32'd0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000);
    chk("rnd_drained", 32'(inst_q.size() + exp_q.size()), 32'd0);

    // Reset in the middle of a stalled stream
    @(negedge clk);
    res_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hF800;
    {alu_zf, alu_sf, alu_of, alu_cf} = 4'b0001;
    repeat (2) @(negedge clk);
    #1 chk("mr_full", 32'({alu_valid, res_valid, res_kind, res_cond}), 32'({2'b11, 2'b01, 1'b1}));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1 check_all_zero("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
